// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one request at a time to instruction
// memory, buffers the returned word for decode, and steers the PC register.
// A redirect flushes the buffer. A response that was already in flight when
// the redirect arrived is dropped on return via the kill flag.
module fetch_ctrl #(
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  NOP   = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_load,
  output logic [WIDTH-1:0] next_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr
);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           r_state;
  logic             r_kill;
  logic             r_if_valid;
  logic [WIDTH-1:0] r_if_pc;
  logic [WIDTH-1:0] r_if_instr;

  logic             w_redirect;
  logic             w_capture;
  logic             w_consume;
  logic             w_req;
  logic [WIDTH-1:0] w_redirect_tgt;

  // Request, capture and PC-steering decisions for the current cycle
  always_comb begin
    w_redirect     = !rst && redirect_valid;
    w_capture      = !rst && !redirect_valid && (r_state == S_WAIT) &&
                     imem_rvalid && !r_kill;
    w_consume      = r_if_valid && !stall;
    w_req          = !rst && !redirect_valid && (r_state == S_REQ) &&
                     !(r_if_valid && stall);
    w_redirect_tgt = redirect_pc & ALIGN_MASK;
    pc_load        = w_redirect || w_capture;
    next_pc        = pc;
    if (w_redirect) begin
      next_pc = w_redirect_tgt;
    end else if (w_capture) begin
      next_pc = pc + PC_STEP;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

  // FSM, kill flag and decode buffer; an empty buffer always holds NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= NOP;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
      r_if_instr <= NOP;
      if (r_state == S_WAIT) begin
        if (imem_rvalid) begin
          r_state <= S_REQ;
          r_kill  <= 1'b0;
        end else begin
          r_kill  <= 1'b1;
        end
      end
    end else begin
      if (r_state == S_REQ) begin
        if (w_req && imem_ready) begin
          r_state <= S_WAIT;
        end
      end else if (imem_rvalid) begin
        r_state <= S_REQ;
        r_kill  <= 1'b0;
      end
      if (w_capture) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= pc;
        r_if_instr <= imem_rdata;
      end else if (w_consume) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam int unsigned W   = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pc;
  logic          pc_load;
  logic [W-1:0]  next_pc;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [W-1:0]  imem_rdata;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          stall;
  logic          if_valid;
  logic [W-1:0]  if_pc;
  logic [W-1:0]  if_instr;

  int checks   = 0;
  int failures = 0;

  // Reference model: one outstanding fetch, a stale flag, a one-entry buffer
  bit          m_out;
  bit          m_stale;
  bit          m_bv;
  logic [31:0] m_bpc;
  logic [31:0] m_binstr;

  // Memory model: latency counter for the single accepted request
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat      = -1;

  fetch_ctrl #(.WIDTH(W), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_load(pc_load), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check against model, advance model/PC/memory, end at negedge
  task automatic cycle();
    logic        e_req, cap, redir, e_load;
    logic [31:0] e_npc, n_pc;
    #1;
    redir  = !rst && redirect_valid;
    cap    = !rst && !redirect_valid && m_out && imem_rvalid && !m_stale;
    e_req  = !rst && !redirect_valid && !m_out && !(m_bv && stall);
    e_load = redir || cap;
    e_npc  = redir ? {redirect_pc[31:2], 2'b00} : (cap ? pc + 32'd4 : pc);
    chk("imem_req",  32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, pc);
    chk("pc_load",   32'(pc_load), 32'(e_load));
    chk("next_pc",   next_pc, e_npc);
    chk("if_valid",  32'(if_valid), 32'(m_bv));
    chk("if_instr",  if_instr, m_bv ? m_binstr : NOP);
    if (m_bv) chk("if_pc", if_pc, m_bpc);

    n_pc = rst ? 32'h0 : (e_load ? e_npc : pc);
    if (rst) begin
      m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
    end else if (redirect_valid) begin
      m_bv = 1'b0;
      if (m_out) begin
        if (imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
    end else begin
      if (cap) begin
        m_bv = 1'b1; m_bpc = pc; m_binstr = imem_rdata;
      end else if (m_bv && !stall) begin
        m_bv = 1'b0;
      end
      if (m_out) begin
        if (imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
      end else if (e_req && imem_ready) begin
        m_out = 1'b1;
      end
    end

    if (mem_busy && imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (e_req && imem_ready) begin
      mem_busy = 1'b1;
      mem_addr = pc;
      mem_cnt  = (lat >= 0) ? lat : int'($urandom_range(0, 2));
    end

    @(posedge clk);
    @(negedge clk);
    pc          = n_pc;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? memword(mem_addr) : $urandom;
  endtask

  initial begin
    rst = 1'b1; pc = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0; m_bpc = '0; m_binstr = NOP;
    @(negedge clk);
    cycle();
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc",    if_pc, 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_pc_load",  32'(pc_load), 32'h0);
    cycle();
    rst = 1'b0;

    // Zero-wait fetch at pc 0
    lat = 0; imem_ready = 1'b1;
    #1 chk("zw_req", 32'(imem_req), 32'h1);
    cycle();
    imem_ready = 1'b0;
    #1 chk("zw_pc_load", 32'(pc_load), 32'h1);
    chk("zw_next_pc", next_pc, 32'h4);
    cycle();
    chk("zw_if_valid", 32'(if_valid), 32'h1);
    chk("zw_if_pc",    if_pc, 32'h0);
    chk("zw_if_instr", if_instr, 32'h0050_0093);

    // Stall holds the buffer and blocks requests
    stall = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_req", 32'(imem_req), 32'h0);
      cycle();
      chk("stall_instr", if_instr, 32'h0050_0093);
      chk("stall_valid", 32'(if_valid), 32'h1);
    end
    stall = 1'b0; imem_ready = 1'b0;
    #1 chk("unstall_req", 32'(imem_req), 32'h1);
    cycle();

    // Redirect during WAIT drops the in-flight response
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0; imem_ready = 1'b1; lat = 2;
    cycle();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    #1 chk("rdw_pc_load", 32'(pc_load), 32'h1);
    chk("rdw_next_pc", next_pc, 32'h100);
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rdw_dropped", 32'(if_valid), 32'h0);
    end
    imem_ready = 1'b1;
    #1 chk("rdw_addr", imem_addr, 32'h100);
    chk("rdw_req", 32'(imem_req), 32'h1);

    // Redirect coincident with rvalid
    lat = 0;
    cycle();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1 chk("rdc_rvalid", 32'(imem_rvalid), 32'h1);
    chk("rdc_pc_load", 32'(pc_load), 32'h1);
    chk("rdc_next_pc", next_pc, 32'h200);
    cycle();
    redirect_valid = 1'b0;
    #1 chk("rdc_if_valid", 32'(if_valid), 32'h0);
    chk("rdc_req", 32'(imem_req), 32'h1);
    chk("rdc_addr", imem_addr, 32'h200);

    // PC wrap-around on capture
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    cycle();
    imem_ready = 1'b0;
    #1 chk("wrap_pc_load", 32'(pc_load), 32'h1);
    chk("wrap_next_pc", next_pc, 32'h0);
    cycle();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_valid", 32'(if_valid), 32'h1);

    // Reset while WAIT, then a stray response
    imem_ready = 1'b1; lat = 1;
    cycle();
    imem_ready = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1 chk("rstw_rvalid", 32'(imem_rvalid), 32'h1);
    chk("rstw_pc_load", 32'(pc_load), 32'h0);
    cycle();
    chk("rstw_if_valid", 32'(if_valid), 32'h0);
    chk("rstw_if_instr", if_instr, NOP);

    // Randomized traffic
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom % 101) == 0;
      stall          = ($urandom % 3) == 0;
      imem_ready     = ($urandom % 4) != 0;
      redirect_valid = !rst && (($urandom % 9) == 0);
      redirect_pc    = (($urandom % 5) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (!mem_busy && (($urandom % 7) == 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
